axi_mem_subordinate: RTL and testbench

Parametrised AXI4-Lite memory subordinate: byte-addressed RAM behind five independent channels (AW, W, B, AR, R). It adds byte write strobes, out-of-range SLVERR responses and a configurable read latency. AW and W may arrive in either order or in the same cycle. It sits on the `axi4_if` subordinate modport and replaces the fixed-width, always-OKAY subordinate in the bench and system top.

---
 rtl/axi_mem_subordinate.sv | 175 +++++++++++++++++
 tb/tb_axi_mem_subordinate.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_subordinate.sv
// AXI4-Lite memory subordinate: byte-lane RAM with write strobes, SLVERR on
// out-of-range addresses and a programmable read latency.

module axi_mem_lane #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Asynchronous read: a write landing on the same edge is not yet visible.
  assign rdata = mem[raddr];
endmodule

module axi_mem_subordinate #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int MEM_BYTES = 4096,
  parameter int READ_LAT  = 1
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int DEPTH  = MEM_BYTES / STRB_W;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT  = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [2:0]      LAT_M1 = 3'(READ_LAT - 1);
  localparam logic [1:0]      OKAY   = 2'b00;
  localparam logic [1:0]      SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;

  logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [ADDR_W-1:0]       awaddr_q, ar_addr_q, commit_addr;
  logic [STRB_W-1:0][7:0]  wdata_q, commit_data, rd_lanes;
  logic [STRB_W-1:0]       wstrb_q, commit_strb;
  logic                    commit, w_ok, r_ok;
  logic [2:0]              cnt;
  logic [IDX_W-1:0]        w_idx, r_idx;
  logic                    unused_lo;

  assign AWREADY = !ARESET && (wstate == W_IDLE || wstate == W_DATA);
  assign WREADY  = !ARESET && (wstate == W_IDLE || wstate == W_ADDR);
  assign BVALID  = (wstate == W_RESP);
  assign ARREADY = !ARESET && (rstate == R_IDLE);
  assign RVALID  = (rstate == R_DATA);

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID  & WREADY;
  assign b_hs  = BVALID  & BREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID  & RREADY;

  // ---------------- write path ----------------
  always_comb begin
    wstate_nxt = wstate;
    unique case (wstate)
      W_IDLE: if (aw_hs && w_hs) wstate_nxt = W_RESP;
              else if (aw_hs)    wstate_nxt = W_ADDR;
              else if (w_hs)     wstate_nxt = W_DATA;
      W_ADDR: if (w_hs)  wstate_nxt = W_RESP;
      W_DATA: if (aw_hs) wstate_nxt = W_RESP;
      W_RESP: if (b_hs)  wstate_nxt = W_IDLE;
      default:           wstate_nxt = W_IDLE;
    endcase
  end

  // Whichever half arrived first comes from its holding register, the other live.
  assign commit      = (wstate != W_RESP) && (wstate_nxt == W_RESP);
  assign commit_addr = (wstate == W_ADDR) ? awaddr_q : AWADDR;
  assign commit_data = (wstate == W_DATA) ? wdata_q  : WDATA;
  assign commit_strb = (wstate == W_DATA) ? wstrb_q  : WSTRB;
  assign w_ok        = {1'b0, commit_addr} < LIMIT;
  assign w_idx       = commit_addr[OFF +: IDX_W];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate <= W_IDLE;
      BRESP  <= OKAY;
    end else begin
      wstate <= wstate_nxt;
      if (commit) BRESP <= w_ok ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge ACLK) begin
    if (aw_hs) awaddr_q <= AWADDR;
    if (w_hs) begin
      wdata_q <= WDATA;
      wstrb_q <= WSTRB;
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    rstate_nxt = rstate;
    unique case (rstate)
      R_IDLE:  if (ar_hs)     rstate_nxt = R_WAIT;
      R_WAIT:  if (cnt == '0) rstate_nxt = R_DATA;
      R_DATA:  if (r_hs)      rstate_nxt = R_IDLE;
      default:                rstate_nxt = R_IDLE;
    endcase
  end

  assign r_ok  = {1'b0, ar_addr_q} < LIMIT;
  assign r_idx = ar_addr_q[OFF +: IDX_W];

  // R_WAIT lasts READ_LAT cycles; with READ_LAT=1 it is the single fetch cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate <= R_IDLE;
      cnt    <= '0;
      RDATA  <= '0;
      RRESP  <= OKAY;
    end else begin
      rstate <= rstate_nxt;
      if (ar_hs)                            cnt <= LAT_M1;
      else if (rstate == R_WAIT && cnt != '0) cnt <= cnt - 3'd1;
      if (rstate == R_WAIT && cnt == '0) begin
        RDATA <= r_ok ? rd_lanes : '0;
        RRESP <= r_ok ? OKAY : SLVERR;
      end
    end
  end

  always_ff @(posedge ACLK)
    if (ar_hs) ar_addr_q <= ARADDR;

  // ---------------- byte-lane storage ----------------
  for (genvar i = 0; i < STRB_W; i++) begin : g_lane
    axi_mem_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
      .clk   (ACLK),
      .we    (commit && w_ok && commit_strb[i]),
      .waddr (w_idx),
      .wdata (commit_data[i]),
      .raddr (r_idx),
      .rdata (rd_lanes[i])
    );
  end

  // Sub-word address bits select nothing: accesses hit the containing word.
  assign unused_lo = ^{commit_addr[OFF-1:0], ar_addr_q[OFF-1:0]};
endmodule

// File: tb/tb_axi_mem_subordinate.sv
// Directed self-checking bench for axi_mem_subordinate (32-bit, 4 KiB, READ_LAT=3).

module tb_axi_mem_subordinate;
  localparam int DATA_W = 32, ADDR_W = 13, MEM_BYTES = 4096, READ_LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  axi_mem_subordinate #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES),
                        .READ_LAT(READ_LAT)) dut (
    .ACLK(clk), .ARESET(rst),
    .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready),
    .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
    .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
    .ARADDR(araddr), .ARVALID(arvalid), .ARREADY(arready),
    .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Simultaneous AW+W; reports what the B channel showed right after the handshake.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic bv, output logic [1:0] resp);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int n = 0; n < 20 && !(awready && wready); n++) tick();
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    bv = bvalid; resp = bresp;
    tick();
  endtask

  // lat = edges from the AR handshake edge until RVALID is seen high.
  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int n = 0; n < 20 && !arready; n++) tick();
    tick();
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin tick(); lat++; end
    d = rdata; resp = rresp;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0)
        $display("FAIL reset_hold cyc%0d: rdy/vld=%b want 00000", i,
                 {awready, wready, arready, bvalid, rvalid});
      else pass_cnt++;
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rst = 1'b0;
    #1;
    total++;
    if ({awready, wready, arready} !== 3'b111)
      $display("FAIL reset_release_ready: got %b want 111", {awready, wready, arready});
    else pass_cnt++;
    total++;
    if ({bresp, rresp, rdata} !== 36'h0)
      $display("FAIL reset_outputs: bresp=%b rresp=%b rdata=%h want 0", bresp, rresp, rdata);
    else pass_cnt++;
  endtask

  task automatic test_simul_write();
    logic bv; logic [1:0] r; logic [31:0] d; int lat;
    do_write(13'h010, 32'hDEADBEEF, 4'hF, bv, r);
    total++;
    if (bv !== 1'b1 || r !== 2'b00)
      $display("FAIL simul_b: bvalid=%b bresp=%b want 1/00", bv, r);
    else pass_cnt++;
    total++;
    if ({awready, wready} !== 2'b11)
      $display("FAIL simul_ready_after_b: got %b want 11", {awready, wready});
    else pass_cnt++;
    do_read(13'h010, d, r, lat);
    total++;
    if (lat !== READ_LAT) $display("FAIL read_latency: got %0d want %0d", lat, READ_LAT);
    else pass_cnt++;
    total++;
    if (d !== 32'hDEADBEEF || r !== 2'b00)
      $display("FAIL simul_readback: rdata=%h rresp=%b want deadbeef/00", d, r);
    else pass_cnt++;
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; int lat;
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1; awvalid = 1'b0; bready = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({awready, wready, bvalid} !== 3'b100)
        $display("FAIL w_held cyc%0d: awready/wready/bvalid=%b want 100", i,
                 {awready, wready, bvalid});
      else pass_cnt++;
      tick();
    end
    awaddr = 13'h010; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    total++;
    if (bvalid !== 1'b1 || bresp !== 2'b00)
      $display("FAIL w_first_b: bvalid=%b bresp=%b want 1/00", bvalid, bresp);
    else pass_cnt++;
    tick();
    do_read(13'h010, d, r, lat);
    total++;
    if (d !== 32'hDE22BE44) $display("FAIL strobe_merge: rdata=%h want de22be44", d);
    else pass_cnt++;
  endtask

  task automatic test_range_and_strobe();
    logic bv; logic [1:0] r; logic [31:0] d; int lat;
    do_write(13'h000, 32'h0BADC0DE, 4'hF, bv, r);
    do_write(13'hFFC, 32'h5A5A5A5A, 4'hF, bv, r);
    do_write(13'h1000, 32'hCAFEF00D, 4'hF, bv, r);
    total++;
    if (bv !== 1'b1 || r !== 2'b10) $display("FAIL oor_write_bresp: bvalid=%b bresp=%b want 1/10", bv, r);
    else pass_cnt++;
    do_read(13'h000, d, r, lat);
    total++;
    if (d !== 32'h0BADC0DE) $display("FAIL oor_write_discard: word0=%h want 0badc0de", d);
    else pass_cnt++;
    do_read(13'hFFC, d, r, lat);
    total++;
    if (d !== 32'h5A5A5A5A || r !== 2'b00)
      $display("FAIL last_word_read: rdata=%h rresp=%b want 5a5a5a5a/00", d, r);
    else pass_cnt++;
    do_read(13'h1000, d, r, lat);
    total++;
    if (d !== 32'h0 || r !== 2'b10)
      $display("FAIL oor_read: rdata=%h rresp=%b want 0/10", d, r);
    else pass_cnt++;
    do_write(13'h010, 32'hFFFFFFFF, 4'h0, bv, r);
    total++;
    if (r !== 2'b00) $display("FAIL zero_strobe_bresp: got %b want 00", r);
    else pass_cnt++;
    do_read(13'h013, d, r, lat);
    total++;
    if (d !== 32'hDE22BE44) $display("FAIL zero_strobe_unaligned_read: rdata=%h want de22be44", d);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    awaddr = 13'h030; wdata = 32'h12345678; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bvalid, bresp, awready, wready} !== 5'b10000)
        $display("FAIL b_stall cyc%0d: bvalid/bresp/awready/wready=%b want 10000", i,
                 {bvalid, bresp, awready, wready});
      else pass_cnt++;
      tick();
    end
    bready = 1'b1;
    tick();
    total++;
    if ({bvalid, awready, wready} !== 3'b011)
      $display("FAIL b_release: bvalid/awready/wready=%b want 011", {bvalid, awready, wready});
    else pass_cnt++;
    araddr = 13'h030; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < READ_LAT; i++) tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rvalid !== 1'b1 || rdata !== 32'h12345678 || rresp !== 2'b00 || arready !== 1'b0)
        $display("FAIL r_stall cyc%0d: rvalid=%b rdata=%h rresp=%b arready=%b want 1/12345678/00/0",
                 i, rvalid, rdata, rresp, arready);
      else pass_cnt++;
      tick();
    end
    rready = 1'b1;
    tick();
    total++;
    if ({rvalid, arready} !== 2'b01)
      $display("FAIL r_release: rvalid/arready=%b want 01", {rvalid, arready});
    else pass_cnt++;
  endtask

  task automatic test_same_edge_hazard();
    logic bv; logic [1:0] r; logic [31:0] d; int lat;
    do_write(13'h020, 32'hAAAA0001, 4'hF, bv, r);
    araddr = 13'h020; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < READ_LAT - 1; i++) tick();
    awaddr = 13'h020; wdata = 32'hBBBB0002; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'hAAAA0001 || bvalid !== 1'b1)
      $display("FAIL same_edge_old_data: rvalid=%b rdata=%h bvalid=%b want 1/aaaa0001/1",
               rvalid, rdata, bvalid);
    else pass_cnt++;
    rready = 1'b1;
    tick();
    do_read(13'h020, d, r, lat);
    total++;
    if (d !== 32'hBBBB0002) $display("FAIL same_edge_new_data: rdata=%h want bbbb0002", d);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    logic seen; logic [1:0] r; logic [31:0] d; int lat;
    araddr = 13'h020; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({rvalid, arready} !== 2'b01)
      $display("FAIL mid_read_reset: rvalid/arready=%b want 01", {rvalid, arready});
    else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen |= rvalid; end
    total++;
    if (seen !== 1'b0) $display("FAIL mid_read_no_beat: rvalid seen=%b want 0", seen);
    else pass_cnt++;
    do_read(13'h020, d, r, lat);
    total++;
    if (d !== 32'hBBBB0002 || lat !== READ_LAT)
      $display("FAIL post_reset_read: rdata=%h lat=%0d want bbbb0002/%0d", d, lat, READ_LAT);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_simul_write();
    test_w_before_aw();
    test_range_and_strobe();
    test_backpressure();
    test_same_edge_hazard();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
